// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock-enable divider.
package clk_div_pkg;

  localparam int unsigned DFLT_NCH   = 4;
  localparam int unsigned DFLT_CNT_W = 16;
  localparam int unsigned DFLT_DIV   = 4;

  typedef logic [DFLT_CNT_W-1:0] div_t;

  // Channel-index width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active divisor, pending divisor, registered
// tick / square / pending outputs.
module clk_div_chan import clk_div_pkg::*; #(
  parameter int unsigned CNT_W   = DFLT_CNT_W,
  parameter int unsigned DEF_DIV = DFLT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             sync,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pnd_val;
  logic [CNT_W-1:0] div_m1;
  logic [CNT_W-1:0] half;
  logic             div_zero;
  logic             term;

  // D==0 is excluded before the compare, so div_m1 wrapping is never observed.
  assign div_zero = (div == '0);
  assign div_m1   = div - CNT_W'(1);
  assign half     = div >> 1;
  assign term     = en & ~div_zero & (cnt == div_m1);

  // Counter, divisor reload and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= CNT_W'(DEF_DIV);
      pnd_val <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else if (sync) begin
      // Phase realignment wins over enable and terminal-count reload.
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      if (ld) begin
        div  <= ld_val;
        pend <= 1'b0;
      end else if (pend) begin
        div  <= pnd_val;
        pend <= 1'b0;
      end
    end else begin
      tick <= term;
      if (en) sq <= ~div_zero & (cnt >= half);
      if (div_zero) begin
        // Disabled channel: take a pending divisor on the next edge.
        cnt <= '0;
        if (pend) begin
          div  <= pnd_val;
          pend <= 1'b0;
        end
        if (ld) begin
          pnd_val <= ld_val;
          pend    <= 1'b1;
        end
      end else if (term) begin
        cnt <= '0;
        if (ld) begin
          div  <= ld_val;
          pend <= 1'b0;
        end else if (pend) begin
          div  <= pnd_val;
          pend <= 1'b0;
        end
      end else begin
        if (en) cnt <= cnt + CNT_W'(1);
        if (ld) begin
          pnd_val <= ld_val;
          pend    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider (top).
// Optional feature macro: CLK_DIV_SYNC_EN adds sync_i, which restarts every
// channel phase-aligned and applies all pending divisors in one edge.
module clk_div_multi import clk_div_pkg::*; #(
  parameter int unsigned NCH     = DFLT_NCH,
  parameter int unsigned CNT_W   = DFLT_CNT_W,
  parameter int unsigned DEF_DIV = DFLT_DIV,
  localparam int unsigned CH_W   = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic [NCH-1:0]   pend
);

  logic [NCH-1:0] ld;
  logic           sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // Write decode; out-of-range channel indices match nothing.
  always_comb begin
    ld = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) ld[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .ld     (ld[g]),
      .ld_val (wr_div),
      .sync   (sync),
      .tick   (tick[g]),
      .sq     (sq[g]),
      .pend   (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: the driver pushes the expected outputs
// for each edge, a monitor pops and compares them after that edge.
module tb_clk_div_multi;

  localparam int unsigned NCH = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            sync_i = 1'b0;
  logic            wr_en = 1'b0;
  logic [1:0]      wr_ch = '0;
  logic [15:0]     wr_div = '0;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  sq;
  logic [NCH-1:0]  pend;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NCH     (NCH),
    .CNT_W   (16),
    .DEF_DIV (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
`ifdef CLK_DIV_SYNC_EN
    .sync_i (sync_i),
`endif
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .tick   (tick),
    .sq     (sq),
    .pend   (pend)
  );

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic [NCH-1:0] pend;
    string          name;
  } exp_t;

  exp_t           sbq[$];
  int             compared = 0;
  int             mismatched = 0;
  int             ed[NCH];
  int             ec[NCH];
  logic [NCH-1:0] ep;
  logic [NCH-1:0] esq;
  string          tag = "init";

  task automatic check(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per edge, sampled 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check({e.name, " tick"}, tick, e.tick);
        check({e.name, " sq"}, sq, e.sq);
        check({e.name, " pend"}, pend, e.pend);
      end
    end
  end

  // Drive one edge and push the outputs expected right after it.
  task automatic cyc(input logic e_en, input logic w, input int ch, input int dv, input logic sy);
    exp_t x;
    @(negedge clk);
    en     = e_en;
    wr_en  = w;
    wr_ch  = 2'(ch);
    wr_div = 16'(dv);
    sync_i = sy;
    x.tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sy) begin
        esq[i] = 1'b0;
        ec[i]  = 0;
      end else begin
        x.tick[i] = e_en && (ed[i] != 0) && (ec[i] == ed[i] - 1);
        if (e_en) esq[i] = (ed[i] != 0) && (ec[i] >= ed[i] / 2);
        if (e_en && ed[i] != 0) ec[i] = (ec[i] == ed[i] - 1) ? 0 : ec[i] + 1;
      end
    end
    x.sq   = esq;
    x.pend = ep;
    x.name = tag;
    sbq.push_back(x);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Advance until the next edge is channel ch's terminal count.
  task automatic run_to_term(input int ch);
    for (int k = 0; k < 40 && !(ec[ch] == ed[ch] - 1); k++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Write away from the terminal count so the value goes pending.
  task automatic wr_pending(input int ch, input int val);
    run_to_term(ch);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    ep[ch] = 1'b1;
    cyc(1'b1, 1'b1, ch, val, 1'b0);
  endtask

  task automatic apply(input int ch, input int val);
    run_to_term(ch);
    ep[ch] = 1'b0;
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    ed[ch] = val;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      ed[i] = 4;
      ec[i] = 0;
    end
    ep  = '0;
    esq = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("reset tick", tick, '0);
    check("reset sq", sq, '0);
    check("reset pend", pend, '0);
    rst_n = 1'b1;

    tag = "t1 default div4";
    run(12);

    tag = "t2 ch1 div10";
    wr_pending(1, 10);
    apply(1, 10);
    run(22);

    tag = "t2b same div rewrite";
    wr_pending(0, 4);
    apply(0, 4);
    run(4);

    tag = "t3 ch2 div0";
    wr_pending(2, 0);
    apply(2, 0);
    run(3);
    tag = "t3 ch2 div3";
    ep[2] = 1'b1;
    cyc(1'b1, 1'b1, 2, 3, 1'b0);
    ep[2] = 1'b0;
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    ed[2] = 3;
    ec[2] = 0;
    run(9);

    tag = "t4 ch2 div1";
    wr_pending(2, 1);
    apply(2, 1);
    run(3);
    tag = "t4 en low";
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
    tag = "t4 resume";
    run(6);

    tag = "t5 coincident write";
    run_to_term(0);
    cyc(1'b1, 1'b1, 0, 6, 1'b0);
    ed[0] = 6;
    run(8);

    tag = "t5 last write wins";
    run_to_term(1);
    cyc(1'b1, 1'b0, 0, 0, 1'b0);
    ep[1] = 1'b1;
    cyc(1'b1, 1'b1, 1, 7, 1'b0);
    cyc(1'b1, 1'b1, 1, 9, 1'b0);
    apply(1, 9);
    run(10);

    tag = "t5 bad channel";
    cyc(1'b1, 1'b1, 3, 2, 1'b0);
    run(5);

    tag = "t5 reset pulse";
    run(2);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset tick", tick, '0);
    check("async reset sq", sq, '0);
    check("async reset pend", pend, '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run(9);

`ifdef CLK_DIV_SYNC_EN
    tag = "t6 sync setup";
    wr_pending(0, 3);
    apply(0, 3);
    wr_pending(1, 5);
    apply(1, 5);
    run(2);
    wr_pending(2, 2);
    tag = "t6 sync";
    ep = '0;
    cyc(1'b1, 1'b0, 0, 0, 1'b1);
    ed[2] = 2;
    tag = "t6 aligned";
    run(31);
`endif

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    #2;
    compared++;
    if (sbq.size() > 0) begin
      mismatched++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
